// File: rtl/fpu_round.sv
// Rounding back-end for the single-precision add/sub datapath: two-stage
// valid/ready pipeline producing the IEEE word, {OF,UF,NX} and sticky flags.
module fpu_round #(
  parameter int ACC_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [34:0] in_data,
  input  logic [2:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags,
  input  logic        fflags_clr,
  output logic [2:0]  fflags_acc
);

  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic g,
                                     input logic r, input logic s);
    case (rm)
      3'd1:    return 1'b0;
      3'd2:    return sign & (g | r | s);
      3'd3:    return ~sign & (g | r | s);
      3'd4:    return g;
      default: return g & (r | s | lsb);
    endcase
  endfunction

  // Carry out of the fraction ripples into the exponent, which also turns a
  // rounded-up subnormal into the smallest normal and max finite into inf.
  function automatic logic [30:0] round_mag(input logic [30:0] em, input logic inc);
    return em + {30'd0, inc};
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_inc_q, s1_nx_q, s1_uf_q, s1_spec_q;
  logic [30:0] s1_em_q;
  logic        s1_spec_d, s1_any_d, s1_inc_d;

  logic        out_valid_q;
  logic [31:0] out_data_q, out_data_d;
  logic [2:0]  out_flags_q, out_flags_d;
  logic [2:0]  acc_q, acc_d;
  logic [30:0] mag_d;
  logic        of_d;

  logic s2_load, in_hs, out_hs;

  assign s2_load  = ~out_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_load;
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  // ---- stage 1: increment decision and input-derived flags
  assign s1_spec_d  = (in_data[33:26] == 8'hFF);
  assign s1_any_d   = |in_data[2:0];
  assign s1_inc_d   = ~s1_spec_d & round_inc(in_rm, in_data[34], in_data[3],
                                             in_data[2], in_data[1], in_data[0]);
  assign s1_valid_d = in_hs | (s1_valid_q & ~s2_load);

  always_ff @(posedge clk) begin
    if (rst) s1_valid_q <= 1'b0;
    else     s1_valid_q <= s1_valid_d;
  end

  always_ff @(posedge clk) begin
    if (in_hs) begin
      s1_sign_q <= in_data[34];
      s1_em_q   <= in_data[33:3];
      s1_inc_q  <= s1_inc_d;
      s1_spec_q <= s1_spec_d;
      s1_nx_q   <= ~s1_spec_d & s1_any_d;
      s1_uf_q   <= ~s1_spec_d & s1_any_d & (in_data[33:26] == 8'h00);
    end
  end

  // ---- stage 2: magnitude add, overflow detection, output register
  assign mag_d       = round_mag(s1_em_q, s1_inc_q);
  assign of_d        = ~s1_spec_q & (mag_d[30:23] == 8'hFF);
  assign out_data_d  = {s1_sign_q, mag_d};
  assign out_flags_d = {of_d, s1_uf_q, s1_nx_q | of_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_flags_q <= 3'd0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q  <= out_data_d;
        out_flags_q <= out_flags_d;
      end
    end
  end

  // A clear coinciding with a handshake keeps only the new flags.
  assign acc_d = (ACC_EN != 0) ?
                 ((fflags_clr ? 3'd0 : acc_q) | (out_hs ? out_flags_q : 3'd0)) : 3'd0;

  always_ff @(posedge clk) begin
    if (rst) acc_q <= 3'd0;
    else     acc_q <= acc_d;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_flags  = out_flags_q;
  assign fflags_acc = acc_q;

endmodule
